// File: rtl/uart_tx_serializer_if.sv
// Byte handshake plus serial line bundle between a byte source and uart_tx_serializer.
interface uart_tx_serializer_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 serial_out;
  logic                 tx_busy;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  serial_out,
    input  tx_busy
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output serial_out,
    output tx_busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: sends bytes LSB-first as start/data/stop frames on a registered serial line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input logic                 clk,
  input logic                 reset_n,
  uart_tx_serializer_if.slave bus
);
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] StParity = 3'd4;

  logic parity_q, parity_d;
`endif

  logic [2:0]           state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 line_q, line_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 baud_last;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    line_d    = line_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    baud_last = (baud_q == BaudLast);

    if (state_q != StIdle) begin
      baud_d = baud_last ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (bus.tx_valid && ready_q) begin
          shift_d = bus.tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^bus.tx_data;
`endif
          state_d = StStart;
          line_d  = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      StStart: begin
        if (baud_last) begin
          state_d = StData;
          line_d  = shift_q[0];
        end
      end
      StData: begin
        if (baud_last) begin
          if (bit_q == DataLast) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            line_d  = parity_q;
`else
            state_d = StStop;
            line_d  = 1'b1;
`endif
          end else begin
            // shift_q[1] becomes the new LSB, so it is the next bit on the line
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            line_d  = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_last) begin
          state_d = StStop;
          line_d  = 1'b1;
        end
      end
`endif
      StStop: begin
        // bit counter is reused to count stop bits
        if (baud_last) begin
          if (bit_q == StopLast) begin
            state_d = StIdle;
            bit_d   = '0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        line_d  = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      line_q   <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      line_q   <= line_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.serial_out = line_q;
  assign bus.tx_ready   = ready_q;
  assign bus.tx_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: an 8-bit/1-stop and a 7-bit/2-stop instance.
module tb_uart_tx_serializer;
  localparam int Cpb = 4;
`ifdef UART_TX_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif
  localparam int CycA = (1 + 8 + Par + 1) * Cpb;
  localparam int CycB = (1 + 7 + Par + 2) * Cpb;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   nvec    = 0;
  int   nerr    = 0;

  uart_tx_serializer_if #(.DATA_BITS(8)) ifa ();
  uart_tx_serializer_if #(.DATA_BITS(7)) ifb ();

  uart_tx_serializer #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifa)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(Cpb), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifb)
  );

  always #5 clk = ~clk;

  // Expected line level during bit slot b of a frame; slots past the frame read as idle.
  function automatic logic exp_line(input logic [8:0] d, input int nd, input int b);
    int ones;
    ones = 0;
    if (b == 0) return 1'b0;
    if (b <= nd) return d[b-1];
    if (Par == 1 && b == nd + 1) begin
      for (int i = 0; i < nd; i++) ones += int'(d[i]);
      return (ones % 2) == 1;
    end
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accepting edge (frame cycle 0).
  task automatic handshake_a(input logic [7:0] d, input bit keep);
    int waited;
    waited = 0;
    while (ifa.tx_ready !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    nvec++;
    if (ifa.tx_ready !== 1'b1) begin
      nerr++;
      $display("FAIL hs_ready_a: got %b, want 1", ifa.tx_ready);
    end
    ifa.tx_data  = d;
    ifa.tx_valid = 1'b1;
    tick();
    if (!keep) ifa.tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    ifa.tx_valid = 1'b0;
    ifa.tx_data  = '0;
    ifb.tx_valid = 1'b0;
    ifb.tx_data  = '0;
    reset_n = 1'b0;
    repeat (3) tick();
    nvec += 6;
    if (ifa.serial_out !== 1'b1) begin nerr++; $display("FAIL rst_line_a: got %b, want 1", ifa.serial_out); end
    if (ifa.tx_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready_a: got %b, want 1", ifa.tx_ready); end
    if (ifa.tx_busy !== 1'b0) begin nerr++; $display("FAIL rst_busy_a: got %b, want 0", ifa.tx_busy); end
    if (ifb.serial_out !== 1'b1) begin nerr++; $display("FAIL rst_line_b: got %b, want 1", ifb.serial_out); end
    if (ifb.tx_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready_b: got %b, want 1", ifb.tx_ready); end
    if (ifb.tx_busy !== 1'b0) begin nerr++; $display("FAIL rst_busy_b: got %b, want 0", ifb.tx_busy); end
    reset_n = 1'b1;
    tick();

    // Abort a frame while a data 0 is on the line.
    handshake_a(8'h00, 1'b0);
    repeat (2 * Cpb + 1) tick();
    nvec++;
    if (ifa.serial_out !== 1'b0) begin nerr++; $display("FAIL mid_line_pre: got %b, want 0", ifa.serial_out); end
    #2 reset_n = 1'b0;
    #1;
    nvec += 3;
    if (ifa.serial_out !== 1'b1) begin nerr++; $display("FAIL async_line: got %b, want 1", ifa.serial_out); end
    if (ifa.tx_ready !== 1'b1) begin nerr++; $display("FAIL async_ready: got %b, want 1", ifa.tx_ready); end
    if (ifa.tx_busy !== 1'b0) begin nerr++; $display("FAIL async_busy: got %b, want 0", ifa.tx_busy); end
    #1 reset_n = 1'b1;
    for (int j = 0; j < 6 * Cpb; j++) begin
      tick();
      nvec++;
      if (ifa.serial_out !== 1'b1 || ifa.tx_busy !== 1'b0) begin
        nerr++;
        $display("FAIL post_rst_idle j=%0d: got line=%b busy=%b, want line=1 busy=0",
                 j, ifa.serial_out, ifa.tx_busy);
      end
    end
  endtask

  task automatic test_frames();
    logic [7:0] list[9];
    list[0] = 8'h55;
    list[1] = 8'h07;
    list[2] = 8'h03;
    for (int i = 3; i < 9; i++) list[i] = 8'($urandom);
    for (int i = 0; i < 9; i++) begin
      handshake_a(list[i], 1'b0);
      for (int j = 0; j <= CycA; j++) begin
        logic el;
        el = exp_line(9'(list[i]), 8, j / Cpb);
        nvec += 3;
        if (ifa.serial_out !== el) begin
          nerr++;
          $display("FAIL frame_line d=%h j=%0d: got %b, want %b", list[i], j, ifa.serial_out, el);
        end
        if (ifa.tx_busy !== (j < CycA)) begin
          nerr++;
          $display("FAIL frame_busy d=%h j=%0d: got %b, want %b", list[i], j, ifa.tx_busy, j < CycA);
        end
        if (ifa.tx_ready !== (j >= CycA)) begin
          nerr++;
          $display("FAIL frame_ready d=%h j=%0d: got %b, want %b", list[i], j, ifa.tx_ready,
                   j >= CycA);
        end
        if (j < CycA) tick();
      end
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic test_holdoff();
    logic [7:0] d;
    int pulse;
    d     = 8'($urandom);
    pulse = $urandom_range(Cpb, CycA - Cpb);
    handshake_a(d, 1'b0);
    for (int j = 0; j < CycA + 3 * Cpb; j++) begin
      logic el;
      if (j == pulse) begin
        ifa.tx_data  = 8'hA3;
        ifa.tx_valid = 1'b1;
      end else if (j == pulse + 1) begin
        ifa.tx_valid = 1'b0;
        ifa.tx_data  = 8'($urandom);
      end
      el = exp_line(9'(d), 8, j / Cpb);
      nvec += 2;
      if (ifa.serial_out !== el) begin
        nerr++;
        $display("FAIL holdoff_line j=%0d: got %b, want %b", j, ifa.serial_out, el);
      end
      if (ifa.tx_busy !== (j < CycA)) begin
        nerr++;
        $display("FAIL holdoff_busy j=%0d: got %b, want %b", j, ifa.tx_busy, j < CycA);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] d1, input logic [7:0] d2);
    handshake_a(d1, 1'b1);
    ifa.tx_data = d2;
    for (int j = 0; j <= 2 * CycA + 1; j++) begin
      logic el, eb, er;
      int k;
      k = j - CycA - 1;
      if (j < CycA) begin
        el = exp_line(9'(d1), 8, j / Cpb);
        eb = 1'b1;
        er = 1'b0;
      end else if (j == CycA) begin
        el = 1'b1;
        eb = 1'b0;
        er = 1'b1;
      end else begin
        el = exp_line(9'(d2), 8, k / Cpb);
        eb = (k < CycA);
        er = (k >= CycA);
      end
      nvec += 3;
      if (ifa.serial_out !== el) begin
        nerr++;
        $display("FAIL b2b_line j=%0d: got %b, want %b", j, ifa.serial_out, el);
      end
      if (ifa.tx_busy !== eb) begin
        nerr++;
        $display("FAIL b2b_busy j=%0d: got %b, want %b", j, ifa.tx_busy, eb);
      end
      if (ifa.tx_ready !== er) begin
        nerr++;
        $display("FAIL b2b_ready j=%0d: got %b, want %b", j, ifa.tx_ready, er);
      end
      if (j == CycA + 1) ifa.tx_valid = 1'b0;
      tick();
    end
    for (int j = 0; j < 2 * Cpb; j++) begin
      nvec++;
      if (ifa.tx_busy !== 1'b0) begin
        nerr++;
        $display("FAIL b2b_no_third j=%0d: got %b, want 0", j, ifa.tx_busy);
      end
      tick();
    end
  endtask

  task automatic test_seven_two_stop(input logic [6:0] d);
    nvec++;
    if (ifb.tx_ready !== 1'b1) begin
      nerr++;
      $display("FAIL hs_ready_b: got %b, want 1", ifb.tx_ready);
    end
    ifb.tx_data  = d;
    ifb.tx_valid = 1'b1;
    tick();
    ifb.tx_valid = 1'b0;
    for (int j = 0; j <= CycB; j++) begin
      logic el;
      el = exp_line(9'(d), 7, j / Cpb);
      nvec += 3;
      if (ifb.serial_out !== el) begin
        nerr++;
        $display("FAIL b_line d=%h j=%0d: got %b, want %b", d, j, ifb.serial_out, el);
      end
      if (ifb.tx_busy !== (j < CycB)) begin
        nerr++;
        $display("FAIL b_busy d=%h j=%0d: got %b, want %b", d, j, ifb.tx_busy, j < CycB);
      end
      if (ifb.tx_ready !== (j >= CycB)) begin
        nerr++;
        $display("FAIL b_ready d=%h j=%0d: got %b, want %b", d, j, ifb.tx_ready, j >= CycB);
      end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frames();
    test_holdoff();
    test_back_to_back(8'h00, 8'hFF);
    test_back_to_back(8'($urandom), 8'($urandom));
    test_seven_two_stop(7'h41);
    test_seven_two_stop(7'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmitter. The counterpart to the receive path's start-bit detection and sampling logic. Accepts a parallel byte over a valid/ready handshake and shifts it out LSB-first on a single serial line as a standard asynchronous frame: start bit (0), data bits, optional parity bit, stop bit(s) (1). Sits at the chip's TX pin, driven by the same system clock as the RX side; no separate baud clock.

Parameters:
CLKS_PER_BIT, 16, system clocks per serial bit (baud divisor); legal range 2..65535
DATA_BITS, 8, data bits per frame; legal range 5..9
STOP_BITS, 1, stop bits per frame; legal values 1 or 2

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
tx_data  input  DATA_BITS  byte to send; sampled only on handshake
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a byte (high only in IDLE)
serial_out  output  1  serial line; idle/mark = 1
tx_busy  output  1  high while a frame is on the line (START through last STOP cycle)

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, serial_out=1, tx_ready=1, tx_busy=0, bit counter=0, baud counter=0, shift register=0. Reset mid-frame aborts the frame; the line returns high immediately and no partial frame is resumed after reset release.
- All outputs are registered. No combinational path from tx_valid to any output.
- Handshake: a transfer occurs on a rising edge where tx_valid=1 and tx_ready=1. tx_data is latched into the shift register on that edge. Later changes to tx_data are ignored. tx_valid while tx_ready=0 is ignored (no queueing; the source must hold it).
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- IDLE: serial_out=1, tx_ready=1, tx_busy=0. Handshake -> START. In the same edge: serial_out<=0, tx_ready<=0, tx_busy<=1, baud counter<=0.
- Every bit is held for exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1. When it reaches CLKS_PER_BIT-1 the state advances and the counter wraps to 0.
- START: line 0 for one bit time -> DATA with serial_out<=shift[0].
- DATA: bits sent LSB first. The shift register shifts right once per bit. The bit counter counts 0..DATA_BITS-1. After the last data bit -> PARITY if enabled, else STOP.
- STOP: line 1 for STOP_BITS*CLKS_PER_BIT cycles -> IDLE. On that edge: tx_ready<=1, tx_busy<=0.
- Latency: the first start-bit cycle appears on serial_out exactly 1 clock after the accepting edge.
- Frame length (tx_busy high): (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT clocks, where P=1 with parity and 0 without.
- Back-to-back: with tx_valid held high, the next byte is accepted on the first IDLE cycle. The line therefore stays high for stop time + exactly 1 clock between frames.
- Counter width: the baud counter is clog2(CLKS_PER_BIT) bits; the bit counter is clog2(DATA_BITS+1) bits. No overflow is possible within legal ranges.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP, lasting one bit time. The bit sent is even parity, i.e. the XOR of all DATA_BITS latched bits, computed at handshake from tx_data. Frame length grows by CLKS_PER_BIT.
- Undefined: the PARITY state and parity logic are absent, and DATA goes directly to STOP.

Test Plan:
- Reset with serial_out low mid-frame (CLKS_PER_BIT=4): assert reset_n=0 during DATA -> serial_out=1, tx_ready=1, tx_busy=0 in the same cycle (asynchronous). After release, the line stays 1 until a new handshake.
- Single byte 0x55 (CLKS_PER_BIT=4, 8N1): handshake at edge T -> from T+1 the line carries 0,1,0,1,0,1,0,1,0,1, each held exactly 4 clocks. tx_busy is high for 40 clocks. tx_ready returns 1 at T+41.
- Back-to-back 0x00 then 0xFF with tx_valid held high -> second frame's start bit begins 41 clocks after the first, with 5 clocks of line=1 between the last data bit 0 and the next start bit. Data bits all 1 in the second frame.
- Handshake hold-off: tx_valid pulsed with 0xA3 while tx_busy=1, and tx_data changed mid-frame -> pulse ignored. The frame in flight is unchanged and no extra frame is sent.
- Parity (UART_TX_PARITY_EN defined, CLKS_PER_BIT=4): 0x07 -> parity bit 1. 0x03 -> parity bit 0. Frame length 44 clocks each.
- STOP_BITS=2, DATA_BITS=7, byte 0x41 -> line 0, 1,0,0,0,0,0,1, 1,1. Stop bits held 8 clocks in total (CLKS_PER_BIT=4). tx_busy high for 40 clocks.
